// File: rtl/rp_asg_sweep_ch.sv
// Arbitrary signal generator channel: waveform table with fixed-point phase
// pointer, linear frequency sweep, burst/repetition FSM, and a 6-stage
// scale/offset/saturate output pipeline. Single clock domain.
//
// Trigger handshake: trig_i is a single-cycle request that is only honoured in
// IDLE or LAST; the clock after it is accepted the FSM is in RUN and
// trig_done_o is high for exactly that one cycle. There is no back-pressure.
module rp_asg_sweep_ch #(
  parameter int DW  = 14,
  parameter int RSZ = 14,
  parameter int FW  = 16
) (
  input  logic                dac_clk_i,
  input  logic                dac_rstn_i,
  input  logic                trig_i,
  input  logic                buf_we_i,
  input  logic [RSZ-1:0]      buf_addr_i,
  input  logic [DW-1:0]       buf_wdata_i,
  output logic [DW-1:0]       buf_rdata_o,
  output logic [RSZ-1:0]      buf_rpnt_o,
  input  logic                set_rst_i,
  input  logic [RSZ+FW-1:0]   set_size_i,
  input  logic [RSZ+FW-1:0]   set_ofs_i,
  input  logic [RSZ+FW-1:0]   set_step_i,
  input  logic                set_sweep_en_i,
  input  logic [RSZ+FW:0]     set_sweep_inc_i,
  input  logic [RSZ+FW-1:0]   set_step_end_i,
  input  logic                set_wrap_i,
  input  logic [15:0]         set_ncyc_i,
  input  logic [15:0]         set_rnum_i,
  input  logic [31:0]         set_rdly_i,
  input  logic [DW-1:0]       set_amp_i,
  input  logic [DW-1:0]       set_dc_i,
  input  logic [DW-1:0]       set_first_i,
  input  logic [DW-1:0]       set_last_i,
  input  logic                set_zero_i,
  output logic [DW-1:0]       dac_o,
  output logic                busy_o,
  output logic                trig_done_o,
  output logic [1:0]          dbg_state_o
);

  localparam int PW = RSZ + FW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DELAY = 2'd2,
    S_LAST  = 2'd3
  } state_t;

  // Source select tags carried down the pipeline next to the address
  localparam logic [1:0] SRC_TAB   = 2'd0;
  localparam logic [1:0] SRC_LAST  = 2'd1;
  localparam logic [1:0] SRC_FIRST = 2'd2;
  localparam logic [1:0] SRC_ZERO  = 2'd3;

  localparam logic signed [DW+1:0] SAT_MAX = $signed({3'b000, {(DW-1){1'b1}}});
  localparam logic signed [DW+1:0] SAT_MIN = $signed({3'b111, {(DW-1){1'b0}}});

  state_t          state_q, state_d;
  logic [PW-1:0]   pnt_q, pnt_d;
  logic [PW-1:0]   step_q, step_d;
  logic [15:0]     cyc_q, cyc_d;
  logic [15:0]     rep_q, rep_d;
  logic [31:0]     dly_q, dly_d;
  logic            trig_done_d;

  logic [PW:0]     npnt;
  logic [PW:0]     wpnt;
  logic            wrap_evt;
  logic signed [PW+1:0] sw_sum;
  logic signed [PW+1:0] step_end_s;
  logic [PW-1:0]   step_swept;

  logic [DW-1:0]   mem [2**RSZ];

  logic [1:0]      src_tag;
  logic [RSZ-1:0]  addr_q;
  logic [1:0]      tag1_q, tag2_q;
  logic [DW-1:0]   rd_q;
  logic [DW-1:0]   sel_q;
  logic signed [2*DW:0] prod_q;
  logic signed [DW+1:0] sum_q;
  logic            unused_bits;

  // Pointer advance, wrap detection and clamped sweep step
  always_comb begin
    npnt       = {1'b0, pnt_q} + {1'b0, step_q};
    wrap_evt   = npnt > {1'b0, set_size_i};
    wpnt       = npnt - {1'b0, set_size_i} - {{PW{1'b0}}, 1'b1};
    sw_sum     = $signed({2'b00, step_q}) + $signed({set_sweep_inc_i[PW], set_sweep_inc_i});
    step_end_s = $signed({2'b00, set_step_end_i});
    step_swept = sw_sum[PW-1:0];
    if (!set_sweep_inc_i[PW]) begin
      if (sw_sum >= step_end_s) step_swept = set_step_end_i;
    end else begin
      if (sw_sum <= step_end_s) step_swept = set_step_end_i;
    end
  end

  // FSM next state, pointer/step reloads and burst/repetition counters
  always_comb begin
    state_d     = state_q;
    pnt_d       = pnt_q;
    step_d      = step_q;
    cyc_d       = cyc_q;
    rep_d       = rep_q;
    dly_d       = dly_q;
    trig_done_d = 1'b0;
    if (set_rst_i) begin
      state_d = S_IDLE;
      pnt_d   = set_ofs_i;
      cyc_d   = '0;
      rep_d   = '0;
      dly_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LAST: begin
          if (trig_i) begin
            state_d     = S_RUN;
            pnt_d       = set_ofs_i;
            step_d      = set_step_i;
            cyc_d       = set_ncyc_i;
            rep_d       = set_rnum_i;
            dly_d       = '0;
            trig_done_d = 1'b1;
          end
        end
        S_RUN: begin
          if (set_sweep_en_i) step_d = step_swept;
          if (wrap_evt) begin
            pnt_d = set_wrap_i ? wpnt[PW-1:0] : set_ofs_i;
            if (cyc_q > 16'd1) begin
              cyc_d = cyc_q - 16'd1;
            end else if (cyc_q == 16'd1) begin
              if (rep_q != 16'd0) begin
                state_d = S_DELAY;
                dly_d   = set_rdly_i;
                if (rep_q != 16'hFFFF) rep_d = rep_q - 16'd1;
              end else begin
                state_d = S_LAST;
              end
            end
          end else begin
            pnt_d = npnt[PW-1:0];
          end
        end
        S_DELAY: begin
          if (dly_q == 32'd0) begin
            state_d = S_RUN;
            pnt_d   = set_ofs_i;
            step_d  = set_step_i;
            cyc_d   = set_ncyc_i;
          end else begin
            dly_d = dly_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and control registers
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q     <= S_IDLE;
      pnt_q       <= '0;
      step_q      <= '0;
      cyc_q       <= '0;
      rep_q       <= '0;
      dly_q       <= '0;
      trig_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      pnt_q       <= pnt_d;
      step_q      <= step_d;
      cyc_q       <= cyc_d;
      rep_q       <= rep_d;
      dly_q       <= dly_d;
      trig_done_o <= trig_done_d;
    end
  end

  assign busy_o      = (state_q == S_RUN) || (state_q == S_DELAY);
  assign buf_rpnt_o  = pnt_q[PW-1:FW];
  assign dbg_state_o = state_q;

  // Table write port
  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
  end

  // Independent read-back port
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) buf_rdata_o <= '0;
    else             buf_rdata_o <= mem[buf_addr_i];
  end

  // Source tag for the sample entering the pipeline; zero overrides state
  always_comb begin
    src_tag = SRC_LAST;
    if (set_zero_i)               src_tag = SRC_ZERO;
    else if (state_q == S_RUN)    src_tag = SRC_TAB;
    else if (state_q == S_IDLE)   src_tag = SRC_FIRST;
  end

  // Output pipeline: address, RAM read, select, multiply, offset, saturate
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      addr_q <= '0;
      tag1_q <= SRC_TAB;
      rd_q   <= '0;
      tag2_q <= SRC_TAB;
      sel_q  <= '0;
      prod_q <= '0;
      sum_q  <= '0;
      dac_o  <= '0;
    end else begin
      addr_q <= pnt_q[PW-1:FW];
      tag1_q <= src_tag;
      rd_q   <= mem[addr_q];
      tag2_q <= tag1_q;
      case (tag2_q)
        SRC_TAB:   sel_q <= rd_q;
        SRC_LAST:  sel_q <= set_last_i;
        SRC_FIRST: sel_q <= set_first_i;
        default:   sel_q <= '0;
      endcase
      prod_q <= $signed(sel_q) * $signed({1'b0, set_amp_i});
      sum_q  <= $signed(prod_q[2*DW:DW-1]) + $signed({{2{set_dc_i[DW-1]}}, set_dc_i});
      if (sum_q > SAT_MAX)      dac_o <= SAT_MAX[DW-1:0];
      else if (sum_q < SAT_MIN) dac_o <= SAT_MIN[DW-1:0];
      else                      dac_o <= sum_q[DW-1:0];
    end
  end

  // Fraction bits dropped by the gain shift and the wrap remainder carry
  assign unused_bits = ^{prod_q[DW-2:0], wpnt[PW]};

endmodule

// File: tb/tb_rp_asg_sweep_ch.sv
// Bench for rp_asg_sweep_ch: directed vectors, expected dac_o samples queued
// by the driver and compared by a monitor six clocks later.
module tb_rp_asg_sweep_ch;

  localparam int DW  = 14;
  localparam int RSZ = 14;
  localparam int FW  = 16;
  localparam int PW  = RSZ + FW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trig = 1'b0;
  logic            buf_we = 1'b0;
  logic [RSZ-1:0]  buf_addr = '0;
  logic [DW-1:0]   buf_wdata = '0;
  logic [DW-1:0]   buf_rdata;
  logic [RSZ-1:0]  buf_rpnt;
  logic            set_rst = 1'b0;
  logic [PW-1:0]   set_size = '0;
  logic [PW-1:0]   set_ofs = '0;
  logic [PW-1:0]   set_step = '0;
  logic            set_sweep_en = 1'b0;
  logic [PW:0]     set_sweep_inc = '0;
  logic [PW-1:0]   set_step_end = '0;
  logic            set_wrap = 1'b1;
  logic [15:0]     set_ncyc = '0;
  logic [15:0]     set_rnum = '0;
  logic [31:0]     set_rdly = '0;
  logic [DW-1:0]   set_amp = 14'd8192;
  logic [DW-1:0]   set_dc = '0;
  logic [DW-1:0]   set_first = 14'd55;
  logic [DW-1:0]   set_last = 14'd100;
  logic            set_zero = 1'b0;
  logic [DW-1:0]   dac;
  logic            busy;
  logic            trig_done;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  int            seq[$];
  logic          mark = 1'b0;
  logic [5:0]    mark_sr;

  rp_asg_sweep_ch #(.DW(DW), .RSZ(RSZ), .FW(FW)) dut (
    .dac_clk_i(clk), .dac_rstn_i(rst_n), .trig_i(trig),
    .buf_we_i(buf_we), .buf_addr_i(buf_addr), .buf_wdata_i(buf_wdata),
    .buf_rdata_o(buf_rdata), .buf_rpnt_o(buf_rpnt),
    .set_rst_i(set_rst), .set_size_i(set_size), .set_ofs_i(set_ofs),
    .set_step_i(set_step), .set_sweep_en_i(set_sweep_en),
    .set_sweep_inc_i(set_sweep_inc), .set_step_end_i(set_step_end),
    .set_wrap_i(set_wrap), .set_ncyc_i(set_ncyc), .set_rnum_i(set_rnum),
    .set_rdly_i(set_rdly), .set_amp_i(set_amp), .set_dc_i(set_dc),
    .set_first_i(set_first), .set_last_i(set_last), .set_zero_i(set_zero),
    .dac_o(dac), .busy_o(busy), .trig_done_o(trig_done),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Marks travel six clocks, matching the pointer-to-dac_o latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mark_sr <= '0;
    else        mark_sr <= {mark_sr[4:0], mark};
  end

  // Monitor: pop one expected sample whenever a marked sample reaches dac_o
  always @(negedge clk) begin
    if (mark_sr[5]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dac_unexpected actual=%0h expected=none", dac);
      end else begin
        check(name_q.pop_front(), 32'(dac), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    buf_we    = 1'b1;
    buf_addr  = RSZ'(a);
    buf_wdata = DW'(d);
    tick();
    buf_we    = 1'b0;
  endtask

  task automatic do_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic fsm_rst();
    set_rst = 1'b1;
    tick();
    set_rst = 1'b0;
  endtask

  task automatic play(input string nm);
    for (int i = 0; i < seq.size(); i++) begin
      mark = 1'b1;
      exp_q.push_back(DW'(seq[i]));
      name_q.push_back($sformatf("%s[%0d]", nm, i));
      tick();
    end
    mark = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // Watchdog
  initial begin
    #200us;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Driver
  initial begin
    #22;
    check("rst_dac", 32'(dac), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_trig_done", 32'(trig_done), 0);
    check("rst_rpnt", 32'(buf_rpnt), 0);
    check("rst_state", 32'(dbg_state), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) wr(i, i);
    buf_addr = 14'd5;
    tick();
    check("readback5", 32'(buf_rdata), 5);

    // IDLE outputs first_i
    seq = '{55};
    play("idle_first");
    drain();

    // Basic continuous playback
    set_size = PW'((4 << FW) - 1);
    set_step = PW'(1 << FW);
    set_ofs  = '0;
    set_ncyc = 16'd0;
    do_trig();
    check("trig_done", 32'(trig_done), 1);
    check("busy_run", 32'(busy), 1);
    seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    play("basic");
    check("trig_done_pulse", 32'(trig_done), 0);
    drain();

    // Asynchronous reset in RUN
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dac", 32'(dac), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_state", 32'(dbg_state), 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_ofs = PW'(1 << FW);
    tick();
    do_trig();
    seq = '{1, 2, 3, 0, 1};
    play("restart_ofs");
    drain();

    // Burst with repetition and a trigger ignored in DELAY
    fsm_rst();
    check("setrst_idle", 32'(dbg_state), 0);
    check("setrst_pnt", 32'(buf_rpnt), 1);
    set_ofs  = '0;
    set_ncyc = 16'd2;
    set_rnum = 16'd1;
    set_rdly = 32'd10;
    do_trig();
    seq = '{0, 1, 2, 3, 0, 1, 2, 3,
            100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100,
            0, 1, 2, 3, 0, 1, 2, 3, 100, 100, 100};
    for (int i = 0; i < seq.size(); i++) begin
      mark = 1'b1;
      exp_q.push_back(DW'(seq[i]));
      name_q.push_back($sformatf("burst[%0d]", i));
      if (i == 12) begin
        check("delay_state", 32'(dbg_state), 2);
        trig = 1'b1;
      end
      if (i == 13) begin
        trig = 1'b0;
        check("delay_trig_ignored", 32'(trig_done), 0);
        check("delay_busy", 32'(busy), 1);
      end
      if (i == 26) check("busy_last_run", 32'(busy), 1);
      if (i == 27) begin
        check("last_busy", 32'(busy), 0);
        check("last_state", 32'(dbg_state), 3);
      end
      tick();
    end
    mark = 1'b0;
    drain();

    // Retrigger from LAST; zero repetition delay gives one DELAY clock
    set_size = PW'((2 << FW) - 1);
    set_ncyc = 16'd1;
    set_rnum = 16'd2;
    set_rdly = 32'd0;
    do_trig();
    check("last_retrig", 32'(trig_done), 1);
    seq = '{0, 1, 100, 0, 1, 100, 0, 1, 100, 100};
    play("rdly0");
    drain();

    // Wrap with remainder
    fsm_rst();
    set_size = PW'((5 << FW) - 1);
    set_step = PW'(3 << FW);
    set_ncyc = 16'd0;
    set_rnum = 16'd0;
    set_wrap = 1'b1;
    do_trig();
    seq = '{0, 3, 1, 4, 2, 0, 3};
    play("wrap1");
    drain();

    // Wrap restarting at ofs
    fsm_rst();
    set_wrap = 1'b0;
    do_trig();
    seq = '{0, 3, 0, 3, 0};
    play("wrap0");
    drain();

    // Positive sweep clamps at step_end
    fsm_rst();
    set_wrap      = 1'b1;
    set_size      = PW'((32 << FW) - 1);
    set_step      = PW'(1 << FW);
    set_sweep_en  = 1'b1;
    set_sweep_inc = (PW+1)'(1 << 14);
    set_step_end  = PW'(2 << FW);
    do_trig();
    seq = '{0, 1, 2, 3, 5, 7, 9, 11};
    play("sweep_up");
    drain();

    // Negative sweep clamps at step_end
    fsm_rst();
    set_step      = PW'(2 << FW);
    set_sweep_inc = (PW+1)'(-(1 << 14));
    set_step_end  = PW'(1 << FW);
    do_trig();
    seq = '{0, 2, 3, 5, 6, 7, 8, 9};
    play("sweep_dn");
    drain();
    set_sweep_en = 1'b0;

    // Gain, offset and positive saturation
    fsm_rst();
    wr(0, 8191);
    set_size = PW'((1 << FW) - 1);
    set_step = PW'(1 << FW);
    set_amp  = 14'd16383;
    set_dc   = 14'd8000;
    do_trig();
    seq = '{8191, 8191, 8191};
    play("sat_pos");
    drain();

    // Negative saturation
    fsm_rst();
    wr(0, -8192);
    buf_addr = '0;
    tick();
    check("readback0", 32'(buf_rdata), 32'h2000);
    set_dc = DW'(-100);
    do_trig();
    seq = '{-8192, -8192, -8192};
    play("sat_neg");
    drain();

    // Half gain with offset, then forced zero
    set_amp = 14'd4096;
    set_dc  = 14'd3;
    seq = '{-4093, -4093};
    play("half_gain");
    drain();
    set_amp  = 14'd16383;
    set_dc   = '0;
    set_zero = 1'b1;
    seq = '{0, 0, 0};
    play("zero");
    drain();
    set_zero = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rp_asg_sweep_ch.md
Name: rp_asg_sweep_ch

Overview:
Parametrised next-generation arbitrary signal generator channel, single clock domain.
- Holds a DW-wide waveform table of 2^RSZ entries and reads it with a fixed-point phase pointer.
- Adds linear frequency sweep (chirp) with a clamped end step, and a rebuilt burst/repetition FSM with explicit states.
- Scales, offsets and saturates the output to DW bits.
- Instantiated once per DAC channel inside the ASG top, after trigger qualification.

Parameters:
DW, 14, sample, amplitude and DC width (signed two's complement)
RSZ, 14, log2 of table depth
FW, 16, fractional bits of pointer and step

Ports:
dac_clk_i  in  1  clock for all logic, including the table write port
dac_rstn_i  in  1  reset, asynchronous assert, active-low
trig_i  in  1  qualified trigger, single-cycle pulse
buf_we_i  in  1  table write enable
buf_addr_i  in  RSZ  table address for write and read-back
buf_wdata_i  in  DW  table write data
buf_rdata_o  out  DW  table read-back, 1-cycle latency
buf_rpnt_o  out  RSZ  integer part of the current read pointer
set_rst_i  in  1  synchronous FSM reset
set_size_i  in  RSZ+FW  last valid pointer value (table length minus 1, fixed point)
set_ofs_i  in  RSZ+FW  start pointer
set_step_i  in  RSZ+FW  initial step
set_sweep_en_i  in  1  enable sweep
set_sweep_inc_i  in  RSZ+FW+1  signed per-sample step increment
set_step_end_i  in  RSZ+FW  sweep clamp step
set_wrap_i  in  1  1 = wrap with remainder; 0 = restart at ofs
set_ncyc_i  in  16  table passes per burst; 0 = continuous
set_rnum_i  in  16  extra repetitions; 16'hFFFF = infinite
set_rdly_i  in  32  delay between repetitions, in clocks
set_amp_i  in  DW  unsigned gain; 2^(DW-1) = 1.0
set_dc_i  in  DW  signed offset
set_first_i  in  DW  value output in IDLE
set_last_i  in  DW  value output in DELAY and LAST
set_zero_i  in  1  force output to 0
dac_o  out  DW  DAC sample
busy_o  out  1  FSM in RUN or DELAY
trig_done_o  out  1  pulse when a trigger is accepted

Behaviour:
Reset values:
- All outputs 0, pointer 0, FSM in IDLE.
- Async reset clears the pipeline mid-operation.
- Table contents are not reset.

FSM states and transitions:
- IDLE: any trig_i -> RUN. Load pnt=ofs, step=step_i, cyc=ncyc, rep=rnum. trig_done_o=1 for one cycle.
- RUN: advance pointer every clock.
  - Wrap event: next pointer npnt = pnt+step > size.
  - On wrap with wrap_i=1: pnt = npnt-size-1. With wrap_i=0: pnt = ofs.
  - Each wrap decrements cyc while cyc>1.
  - ncyc=0 means RUN never ends except on set_rst_i.
  - Wrap with cyc==1: rep!=0 -> DELAY with dly=rdly, and rep decrements unless it is FFFF. rep==0 -> LAST.
- DELAY: dly counts down. At dly==0 (including rdly=0, i.e. 1 cycle in DELAY) -> RUN with pnt=ofs, step=step_i, cyc=ncyc.
- LAST: hold. trig_i -> RUN with a full reload, as from IDLE.
- trig_i is ignored in RUN and DELAY; trig_done_o is 0 there.
- set_rst_i has priority over everything: -> IDLE, pnt=ofs, counters cleared.

Sweep:
- Applies only when sweep_en is set and the FSM is in RUN.
- step += sweep_inc every clock.
- Clamp: step stays at step_end once it reaches or passes step_end in the sign direction of inc.
- Step stays unchanged across wraps. It reloads on each repetition.

Pointer arithmetic:
- npnt is computed with RSZ+FW+1 bits; no overflow is lost.
- Table address = pnt[RSZ+FW-1:FW].

Output pipeline (fixed latency 6 clocks from pointer to dac_o):
- Stage 1: address register.
- Stage 2: RAM read.
- Stage 3: source select. Select tag is delayed alongside the data. Priority: zero > state (RUN=table, DELAY/LAST=last_i, IDLE=first_i).
- Stage 4: prod = signed(data) * signed({0,amp}), 2DW+1 bits.
- Stage 5: sum = (prod >>> (DW-1)) + dc, DW+2 bits.
- Stage 6: saturate to [-2^(DW-1), 2^(DW-1)-1].

Table write/read-back:
- Write is synchronous on dac_clk_i.
- Read-back port is independent of the playback read.

Test Plan:
- Reset:
  - Assert dac_rstn_i mid-RUN -> dac_o=0, busy_o=0 immediately.
  - Release, trig -> playback restarts from ofs.
- Basic playback:
  - Table[i]=i, size=(4<<16)-1, step=1<<16, ofs=0, amp=8192, dc=0, ncyc=0.
  - Trig -> dac_o = 0,1,2,3,0,... starting 6 clocks after RUN entry.
- Burst and repetition:
  - ncyc=2, rnum=1, rdly=10, last=100.
  - -> 2 passes, 11 clocks of 100, 2 passes, then 100 held.
  - busy_o falls on LAST entry; a trig in DELAY is ignored.
- Wrap mode:
  - size=(5<<16)-1, step=3<<16, wrap=1 -> addresses 0,3,1,4,2,0.
  - wrap=0 -> addresses 0,3,0,3.
- Sweep:
  - step=1<<16, inc=+(1<<14), end=2<<16 -> step reaches 2<<16 after 4 clocks and stays there.
  - Negative inc clamps symmetrically.
- Scaling and saturation:
  - Table=8191, amp=16383, dc=8000 -> dac_o=8191.
  - Table=-8192, dc=-100 -> -8192.
  - set_zero_i -> 0.
